// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: two request channels and a shared read-response path.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_wr;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Combinational two-way grant selection. Round-robin on contention when MEM_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with requester 0 winning.
module mem_arb_grant (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On contention the requester that did not win last time is served.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = 2'b00;
    if (valid[0])      grant = 2'b01;
    else if (valid[1]) grant = 2'b10;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous RAM port (1-cycle read latency).
// Arbitration policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave req,
  output logic              mem_chipselect,
  output logic              mem_wr_en,
  output logic              mem_outenable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_dataout
);

  arb_state_t        state;
  logic [1:0]        grant;
  logic              last_grant;
  logic              owner;
  logic              wr_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              sel;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_grant u_grant (
    .valid (req.req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  assign sel       = grant[1];
  assign sel_wr    = sel ? req.req_wr[1] : req.req_wr[0];
  assign sel_addr  = sel ? req.req_addr1 : req.req_addr0;
  assign sel_wdata = sel ? req.req_wdata1 : req.req_wdata0;

  // Ready is offered combinationally in IDLE so acceptance costs no extra cycle.
  assign req.req_ready = (rst_n && state == IDLE) ? grant : 2'b00;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      wr_q           <= 1'b0;
      rsp_valid_q    <= 2'b00;
      rsp_rdata_q    <= '0;
      mem_chipselect <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_outenable  <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner          <= sel;
            last_grant     <= sel;
            wr_q           <= sel_wr;
            mem_chipselect <= 1'b1;
            mem_wr_en      <= sel_wr;
            mem_outenable  <= !sel_wr;
            mem_address    <= sel_addr;
            mem_data       <= sel_wdata;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          mem_chipselect <= 1'b0;
          mem_wr_en      <= 1'b0;
          if (wr_q) begin
            mem_outenable <= 1'b0;
            state         <= IDLE;
          end else begin
            state <= RDWAIT;
          end
        end
        // RAM data is valid now, one cycle after the read access.
        RDWAIT: begin
          mem_outenable <= 1'b0;
          rsp_rdata_q   <= mem_dataout;
          rsp_valid_q   <= owner ? 2'b10 : 2'b01;
          state         <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expectations on acceptance, a monitor checks every cycle.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          mem_chipselect, mem_wr_en, mem_outenable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_dataout;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (bus),
    .mem_chipselect (mem_chipselect),
    .mem_wr_en      (mem_wr_en),
    .mem_outenable  (mem_outenable),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_dataout    (mem_dataout)
  );

  logic v0 = 0, v1 = 0, w0 = 0, w1 = 0;
  logic [7:0] a0 = 0, a1 = 0, d0 = 0, d1 = 0;
  assign bus.req_valid  = {v1, v0};
  assign bus.req_wr     = {w1, w0};
  assign bus.req_addr0  = a0;
  assign bus.req_addr1  = a1;
  assign bus.req_wdata0 = d0;
  assign bus.req_wdata1 = d1;

  // Synchronous RAM with one-cycle read latency.
  logic [7:0] ram [256];
  logic [7:0] ram_out = 8'h00;
  assign mem_dataout = ram_out;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_wr_en) ram[mem_address] <= mem_data;
      else           ram_out <= ram[mem_address];
    end
  end

  typedef struct {
    int         owner;
    logic [7:0] data;
    int         due;
  } rsp_exp_t;

  logic [7:0] ref_mem [256];
  rsp_exp_t   exp_q [$];
  arb_req_t   wexp_q [$];
  int         grant_log [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0, next_free = 0, acc_cyc = -100, rd_acc_cyc = -100, wr_acc_cyc = -100;
  int last_owner = 1;
  bit first_seen = 0;
  logic [1:0] first_ready = 2'b00;
  bit window = 0;
  int rsp_in_window = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      ram[k]     = 8'h00;
      ref_mem[k] = 8'h00;
    end
  end

  // Monitor: timing and data expectations derived from the transaction rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          {1'b0, bus.req_ready, bus.rsp_valid, mem_chipselect, mem_wr_en, mem_outenable,
           mem_address, mem_data, bus.rsp_rdata}, 32'd0);
      exp_q.delete();
      wexp_q.delete();
      next_free  = cyc;
      acc_cyc    = -100;
      rd_acc_cyc = -100;
      wr_acc_cyc = -100;
      last_owner = 1;
      first_seen = 0;
    end else begin
      logic [1:0] exp_ready;
      logic [1:0] g;
      rsp_exp_t   e;
      arb_req_t   we;
      cyc++;

      chk("chipselect", 32'(mem_chipselect), 32'(acc_cyc == cyc - 1));
      chk("wr_en", 32'(mem_wr_en), 32'(wr_acc_cyc == cyc - 1));
      chk("outenable", 32'(mem_outenable),
          32'((rd_acc_cyc == cyc - 1) || (rd_acc_cyc == cyc - 2)));
      if (mem_wr_en && mem_chipselect) begin
        if (wexp_q.size() == 0) begin
          chk("write_unexpected", 32'(mem_wr_en), 32'd0);
        end else begin
          we = wexp_q.pop_front();
          chk("write_addr", 32'(mem_address), 32'(we.addr));
          chk("write_data", 32'(mem_data), 32'(we.wdata));
        end
      end

      if (window && bus.rsp_valid != 2'b00) rsp_in_window++;
      if (bus.rsp_valid == 2'b00 && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing", 32'(bus.rsp_valid), 32'(e.owner == 1 ? 2'b10 : 2'b01));
      end
      if (bus.rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("rsp_spurious", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_owner", 32'(bus.rsp_valid), 32'(e.owner == 1 ? 2'b10 : 2'b01));
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end

      if (cyc < next_free || bus.req_valid == 2'b00) exp_ready = 2'b00;
      else if (bus.req_valid == 2'b01)               exp_ready = 2'b01;
      else if (bus.req_valid == 2'b10)               exp_ready = 2'b10;
      else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_ready = (last_owner == 1) ? 2'b01 : 2'b10;
`else
        exp_ready = 2'b01;
`endif
      end
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (!first_seen) begin
        first_seen  = 1;
        first_ready = bus.req_ready;
      end

      g = bus.req_ready & bus.req_valid;
      if (g != 2'b00) begin
        int own;
        own = g[1] ? 1 : 0;
        last_owner = own;
        grant_log.push_back(own);
        acc_cyc = cyc;
        if (bus.req_wr[own]) begin
          wr_acc_cyc = cyc;
          ref_mem[own ? a1 : a0] = own ? d1 : d0;
          wexp_q.push_back('{wr: 1'b1, addr: (own ? a1 : a0), wdata: (own ? d1 : d0)});
          next_free = cyc + 2;
        end else begin
          rd_acc_cyc = cyc;
          exp_q.push_back('{owner: own, data: ref_mem[own ? a1 : a0], due: cyc + 3});
          next_free = cyc + 4;
        end
      end
    end
  end

  task automatic issue(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
    bit got = 0;
    if (i == 0) begin w0 = wr; a0 = a; d0 = d; v0 = 1; end
    else        begin w1 = wr; a1 = a; d1 = d; v1 = 1; end
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1;
    end
    chk("accept_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (i == 0) v0 = 0;
    else        v1 = 0;
  endtask

  task automatic rnd_stream(input int i);
    repeat (25) begin
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
      issue(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom));
    end
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 0;
    // Reset with both requesters already valid
    fork
      begin repeat (3) @(posedge clk); #1 rst_n = 1; end
      issue(0, 1'b0, 8'd3, 8'd0);
      issue(1, 1'b0, 8'd12, 8'd0);
    join
    chk("first_grant_after_reset", 32'(first_ready), 32'h1);
    drain();

    // Write then read back through requester 0
    issue(0, 1'b1, 8'd5, 8'h2A);
    issue(0, 1'b0, 8'd5, 8'h00);
    drain();

    // Continuous contention
    grant_log.delete();
    fork
      repeat (4) issue(0, 1'b0, 8'd3, 8'd0);
      repeat (4) issue(1, 1'b0, 8'd12, 8'd0);
    join
    drain();
    chk("grant_log_len", 32'(grant_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      for (int k = 1; k < 4; k++) chk("rr_alternate", 32'(grant_log[k]), 32'(1 - grant_log[k-1]));
`else
      for (int k = 0; k < 4; k++) chk("fixed_priority", 32'(grant_log[k]), 32'd0);
`endif
    end

    // Requester 1 fills 10..19, requester 0 reads them back
    for (int k = 10; k < 20; k++) issue(1, 1'b1, 8'(k), 8'($urandom));
    for (int k = 10; k < 20; k++) issue(0, 1'b0, 8'(k), 8'd0);
    drain();

    // Randomized traffic from both requesters
    fork
      rnd_stream(0);
      rnd_stream(1);
    join
    drain();

    // Reset while a read of address 7 sits in RDWAIT
    window = 1;
    rsp_in_window = 0;
    issue(0, 1'b0, 8'd7, 8'd0);
    @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #1 window = 0;
    chk("no_rsp_after_abort", 32'(rsp_in_window), 32'd0);
    issue(1, 1'b1, 8'd7, 8'h55);
    issue(0, 1'b0, 8'd7, 8'd0);
    drain();

    // Requester 0 raises and drops valid while requester 1 is being served
    issue(1, 1'b0, 8'd20, 8'd0);
    w0 = 1; a0 = 8'd21; d0 = 8'h99; v0 = 1;
    repeat (2) @(posedge clk);
    #1 v0 = 0;
    drain();

    chk("scoreboard_empty", 32'(exp_q.size() + wexp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, memory data width in bits.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-005 Ports req_valid[1:0] SHALL be input, 2 bits: request valid, one bit per requester.
REQ-006 Ports req_ready[1:0] SHALL be output, 2 bits: request accepted, one bit per requester.
REQ-007 Ports req_wr[1:0] SHALL be input, 2 bits: 1 = write, 0 = read.
REQ-008 Ports req_addr0 and req_addr1 SHALL be input, ADDR_W each: request addresses.
REQ-009 Ports req_wdata0 and req_wdata1 SHALL be input, DATA_W each: write data.
REQ-010 Ports rsp_valid[1:0] SHALL be output, 2 bits: one-cycle read-data-valid pulse per requester.
REQ-011 Port rsp_rdata SHALL be output, DATA_W: read data, shared by both requesters.
REQ-012 Ports mem_chipselect, mem_wr_en and mem_outenable SHALL be output, 1 bit each: RAM port controls.
REQ-013 Port mem_address SHALL be output, ADDR_W; port mem_data SHALL be output, DATA_W: RAM address and write data.
REQ-014 Port mem_dataout SHALL be input, DATA_W: RAM read data, valid one clk after a read access.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RDWAIT and RESP.
REQ-016 In IDLE with any req_valid high, the arbiter SHALL pulse req_ready for exactly one requester, register its wr/addr/wdata, record the owner and go to ACCESS next cycle.
REQ-017 A transfer SHALL occur only when req_valid and req_ready are both high; requesters SHALL hold stable until accepted.
REQ-018 In ACCESS (one cycle) the block SHALL drive mem_chipselect=1, mem_address and mem_data from the registers, mem_wr_en=req_wr, and mem_outenable=!req_wr.
REQ-019 After a write ACCESS the FSM SHALL return to IDLE; write-to-next-grant spacing is 2 cycles.
REQ-020 After a read ACCESS the FSM SHALL enter RDWAIT (outenable held 1, chipselect 0), capture mem_dataout into rsp_rdata at the end of RDWAIT, then enter RESP.
REQ-021 In RESP, rsp_valid[owner] SHALL be 1 for exactly one cycle; rsp_rdata SHALL hold until the next read capture; FSM then returns to IDLE.
REQ-022 Read latency from the req_ready cycle to rsp_valid SHALL be 3 cycles.
REQ-023 Outside ACCESS/RDWAIT, mem_chipselect, mem_wr_en and mem_outenable SHALL be 0.
REQ-024 req_ready SHALL be 0 in every state except IDLE; new requests arriving during a transaction SHALL wait, never be dropped.
REQ-025 On simultaneous valid requests, selection SHALL follow REQ-031/032; a single valid requester SHALL always be granted.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, all mem_* outputs=0, and last-grant pointer=1 (so requester 0 wins first).
REQ-027 Reset mid-transaction SHALL abandon the transaction with no rsp_valid; no partial write is guaranteed.
REQ-028 Release of rst_n SHALL be synchronised externally; first grant possible on the first clk edge after release.

Configuration
REQ-029 The feature SHALL be controlled by macro MEM_ARB_ROUND_ROBIN_EN.
REQ-030 Only the policy SHALL differ; timing and interface are identical.
REQ-031 With MEM_ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not granted last; the pointer updates on every grant.
REQ-032 Without it: fixed priority, requester 0 always wins contention; the pointer is unused.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the FSM state enum (arb_state_t), default ADDR_W/DATA_W constants, and a request struct (wr, addr, wdata).
REQ-034 Grant selection SHALL be a sub-module mem_arb_grant (valid bits + last pointer -> one-hot grant), combinational, instanced once.

Verification
REQ-035 Reset with both valid: rst_n=0 for 3 cycles -> all outputs 0, no req_ready during reset, req_ready=2'b01 on the first IDLE cycle.
REQ-036 Req0 writes addr 5 with 0x2A, then reads addr 5 -> mem_wr_en pulse with addr 5 / data 0x2A; rsp_valid[0] 3 cycles after the read grant, rsp_rdata=0x2A.
REQ-037 Both valid continuously, reads to addr 3 (r0) and 12 (r1), round-robin build -> grants alternate 0,1,0,1; fixed build -> requester 0 granted every transaction.
REQ-038 Req1 writes addr 10..19 with 10 random values, then req0 reads 10..19 -> each rsp_rdata matches the written value, rsp_valid only on bit 0.
REQ-039 rst_n asserted in RDWAIT of a read to addr 7 -> no rsp_valid; after release the FSM is in IDLE and the next request completes normally.
REQ-040 A requester drops valid while another is mid-transaction -> no spurious req_ready or rsp_valid; mem_chipselect high only in ACCESS cycles.
